// File: rtl/gemmm2s_pkg.sv
// Shared types and constants for the AXI write-to-stream bridge.
// Holds the FSM state encoding, AXI BRESP/AWBURST codes and the destination-width helper.
package gemmm2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] BRESP_OKAY    = 2'b00;
    localparam logic [1:0] BRESP_SLVERR  = 2'b10;

    localparam logic [1:0] AWBURST_FIXED = 2'b00;
    localparam logic [1:0] AWBURST_INCR  = 2'b01;
    localparam logic [1:0] AWBURST_WRAP  = 2'b10;

    // A single destination still needs a 1-bit tdest port.
    function automatic int dest_width(input int num_chan);
        return (num_chan > 1) ? $clog2(num_chan) : 1;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered valid/data/ready outputs, full throughput, one cycle latency.
// Ready is low during reset.
module skid_buffer #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    logic [WORD_WIDTH-1:0] out_data_reg;
    logic [WORD_WIDTH-1:0] skid_data_reg;
    logic                  out_valid_reg;
    logic                  skid_valid_reg;
    logic                  s_ready_reg;
    logic                  in_fire;
    logic                  out_free;

    assign in_fire  = s_valid && s_ready_reg;
    assign out_free = !out_valid_reg || m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_reg   <= '0;
            skid_data_reg  <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            s_ready_reg    <= 1'b0;
        end else begin
            if (out_free) begin
                // The skid entry, when full, is always older than any new input.
                if (skid_valid_reg) begin
                    out_data_reg   <= skid_data_reg;
                    out_valid_reg  <= 1'b1;
                    skid_valid_reg <= 1'b0;
                end else begin
                    out_valid_reg <= in_fire;
                    if (in_fire) begin
                        out_data_reg <= s_data;
                    end
                end
                s_ready_reg <= 1'b1;
            end else begin
                if (in_fire) begin
                    skid_data_reg  <= s_data;
                    skid_valid_reg <= 1'b1;
                end
                s_ready_reg <= !(skid_valid_reg || in_fire);
            end
        end
    end

    assign s_ready = s_ready_reg;
    assign m_data  = out_data_reg;
    assign m_valid = out_valid_reg;

endmodule

// File: rtl/gemmm2s_v3.sv
// AXI4 write-burst slave that forwards W beats onto an AXI-Stream master, one burst at a time.
// Optional GEMMM2S_SKID_EN registers all four channels through skid buffers.
module gemmm2s_v3
    import gemmm2s_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 13,
    parameter int C_NUM_CHAN       = 4,
    parameter int C_DEST_WIDTH     = dest_width(C_NUM_CHAN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [C_AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [C_AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [C_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic [C_DEST_WIDTH-1:0]     m_axis_tdest,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);

    localparam logic [2:0] SIZE_LOG2 = 3'($clog2(C_AXI_DATA_WIDTH / 8));

    // Core-side channel signals (either wired straight to ports or through skid buffers)
    logic [C_AXI_ID_WIDTH-1:0]   aw_id;
    logic [C_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_valid, aw_ready;
    logic [C_AXI_DATA_WIDTH-1:0] w_data;
    logic                        w_last, w_valid, w_ready;
    logic [C_AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                  b_resp;
    logic                        b_valid, b_ready;
    logic [C_AXI_DATA_WIDTH-1:0] t_data;
    logic                        t_last, t_valid, t_ready;
    logic [C_DEST_WIDTH-1:0]     t_dest;
    logic [C_DEST_WIDTH-1:0]     aw_dest;

    state_t                      state_reg, state_next;
    logic                        err_reg, err_next;
    logic [7:0]                  cnt_reg, cnt_next;
    logic [7:0]                  len_reg, len_next;
    logic [C_AXI_ID_WIDTH-1:0]   bid_reg, bid_next;
    logic [C_DEST_WIDTH-1:0]     dest_reg, dest_next;
    logic                        at_len;

    generate
        if (C_NUM_CHAN > 1) begin : g_dest
            assign aw_dest = aw_addr[C_AXI_ADDR_WIDTH-1 -: C_DEST_WIDTH];
        end else begin : g_dest_zero
            assign aw_dest = '0;
        end
    endgenerate

    assign at_len = (cnt_reg == len_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            bid_reg   <= '0;
            dest_reg  <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            bid_reg   <= bid_next;
            dest_reg  <= dest_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        bid_next   = bid_reg;
        dest_next  = dest_reg;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        t_valid    = 1'b0;
        t_data     = '0;
        t_last     = 1'b0;
        b_valid    = 1'b0;
        b_resp     = BRESP_OKAY;
        case (state_reg)
            ST_IDLE: begin
                aw_ready = !reset;
                if (aw_valid && !reset) begin
                    bid_next  = aw_id;
                    dest_next = aw_dest;
                    len_next  = aw_len;
                    cnt_next  = '0;
                    // Unsupported burst shapes are swallowed and answered with SLVERR.
                    if (aw_burst != AWBURST_INCR || aw_size != SIZE_LOG2) begin
                        err_next   = 1'b1;
                        state_next = ST_DRAIN;
                    end else begin
                        err_next   = 1'b0;
                        state_next = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                t_valid = w_valid;
                t_data  = w_data;
                t_last  = w_last || at_len;
                w_ready = t_ready;
                if (w_valid && t_ready) begin
                    cnt_next = cnt_reg + 8'd1;
                    if (w_last != at_len) begin
                        err_next = 1'b1;
                    end
                    if (w_last) begin
                        state_next = ST_RESP;
                    end else if (at_len) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_ready = 1'b1;
                if (w_valid && w_last) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                b_valid = 1'b1;
                b_resp  = err_reg ? BRESP_SLVERR : BRESP_OKAY;
                if (b_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign b_id   = bid_reg;
    assign t_dest = dest_reg;

`ifdef GEMMM2S_SKID_EN
    localparam int AW_W = C_AXI_ID_WIDTH + C_AXI_ADDR_WIDTH + 8 + 3 + 2;
    localparam int W_W  = C_AXI_DATA_WIDTH + 1;
    localparam int B_W  = C_AXI_ID_WIDTH + 2;
    localparam int T_W  = C_AXI_DATA_WIDTH + 1 + C_DEST_WIDTH;

    skid_buffer #(.WORD_WIDTH(AW_W)) u_aw_skid (
        .clk     (clk),
        .reset   (reset),
        .s_data  ({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst}),
        .s_valid (s_axi_awvalid),
        .s_ready (s_axi_awready),
        .m_data  ({aw_id, aw_addr, aw_len, aw_size, aw_burst}),
        .m_valid (aw_valid),
        .m_ready (aw_ready)
    );

    skid_buffer #(.WORD_WIDTH(W_W)) u_w_skid (
        .clk     (clk),
        .reset   (reset),
        .s_data  ({s_axi_wdata, s_axi_wlast}),
        .s_valid (s_axi_wvalid),
        .s_ready (s_axi_wready),
        .m_data  ({w_data, w_last}),
        .m_valid (w_valid),
        .m_ready (w_ready)
    );

    skid_buffer #(.WORD_WIDTH(B_W)) u_b_skid (
        .clk     (clk),
        .reset   (reset),
        .s_data  ({b_id, b_resp}),
        .s_valid (b_valid),
        .s_ready (b_ready),
        .m_data  ({s_axi_bid, s_axi_bresp}),
        .m_valid (s_axi_bvalid),
        .m_ready (s_axi_bready)
    );

    skid_buffer #(.WORD_WIDTH(T_W)) u_t_skid (
        .clk     (clk),
        .reset   (reset),
        .s_data  ({t_data, t_last, t_dest}),
        .s_valid (t_valid),
        .s_ready (t_ready),
        .m_data  ({m_axis_tdata, m_axis_tlast, m_axis_tdest}),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );
`else
    assign aw_id         = s_axi_awid;
    assign aw_addr       = s_axi_awaddr;
    assign aw_len        = s_axi_awlen;
    assign aw_size       = s_axi_awsize;
    assign aw_burst      = s_axi_awburst;
    assign aw_valid      = s_axi_awvalid;
    assign s_axi_awready = aw_ready;
    assign w_data        = s_axi_wdata;
    assign w_last        = s_axi_wlast;
    assign w_valid       = s_axi_wvalid;
    assign s_axi_wready  = w_ready;
    assign s_axi_bid     = b_id;
    assign s_axi_bresp   = b_resp;
    assign s_axi_bvalid  = b_valid;
    assign b_ready       = s_axi_bready;
    assign m_axis_tdata  = t_data;
    assign m_axis_tlast  = t_last;
    assign m_axis_tdest  = t_dest;
    assign m_axis_tvalid = t_valid;
    assign t_ready       = m_axis_tready;
`endif

endmodule

// File: tb/tb_gemmm2s_v3.sv
// Scoreboard bench for gemmm2s_v3: directed bursts push expected T beats and B responses,
// a negedge monitor pops and compares on every handshake and checks stall stability.
module tb_gemmm2s_v3;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  s_axi_awid;
    logic [12:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [0:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [1:0]  m_axis_tdest;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  dest;
    } t_exp_t;

    typedef struct {
        logic [0:0] id;
        logic [1:0] resp;
    } b_exp_t;

    t_exp_t t_q[$];
    b_exp_t b_q[$];

    int   total = 0;
    int   bad   = 0;
    logic toggle_en = 1'b0;
    logic stall_pending = 1'b0;
    logic [31:0] stall_data = '0;

    gemmm2s_v3 dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    // Stream sink: always ready, or alternating 1/0 when toggling is enabled.
    initial m_axis_tready = 1'b1;
    always @(posedge clk) begin
        #1;
        m_axis_tready = toggle_en ? ~m_axis_tready : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_tdata", 64'(m_axis_tdata), 64'(stall_data));
            end
            stall_pending = m_axis_tvalid && !m_axis_tready;
            stall_data    = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                $display("T beat data=0x%08h last=%0d dest=%0d", m_axis_tdata, m_axis_tlast, m_axis_tdest);
                if (t_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL t_unexpected: got data 0x%0h expected no beat", m_axis_tdata);
                end else begin
                    t_exp_t e;
                    e = t_q.pop_front();
                    chk("t_data", 64'(m_axis_tdata), 64'(e.data));
                    chk("t_last", 64'(m_axis_tlast), 64'(e.last));
                    chk("t_dest", 64'(m_axis_tdest), 64'(e.dest));
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                $display("B resp id=%0d bresp=%0d", s_axi_bid, s_axi_bresp);
                if (b_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected: got bresp %0d expected no response", s_axi_bresp);
                end else begin
                    b_exp_t e;
                    e = b_q.pop_front();
                    chk("b_id", 64'(s_axi_bid), 64'(e.id));
                    chk("b_resp", 64'(s_axi_bresp), 64'(e.resp));
                end
            end
        end
    end

    task automatic push_t(input logic [31:0] d, input logic l, input logic [1:0] dest);
        t_exp_t e;
        e.data = d;
        e.last = l;
        e.dest = dest;
        t_q.push_back(e);
    endtask

    task automatic push_b(input logic [0:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id   = id;
        e.resp = resp;
        b_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_aw(input logic [0:0] id, input logic [12:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awsize  = size;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axi_awready && n < 300);
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL aw_timeout: got awready 0 expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic l);
        int n = 0;
        s_axi_wdata  = d;
        s_axi_wlast  = l;
        s_axi_wvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axi_wready && n < 300);
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL w_timeout: got wready 0 expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((t_q.size() != 0 || b_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d T and %0d B pending expected 0", t_q.size(), b_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        s_axi_awid    = '0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awsize  = '0;
        s_axi_awburst = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wlast   = 1'b0;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_wready", 64'(s_axi_wready), 64'd0);
        chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("rst_bresp", 64'(s_axi_bresp), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        s_axi_wvalid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_awready", 64'(s_axi_awready), 64'd1);
        chk("idle_wready", 64'(s_axi_wready), 64'd0);

        // Nominal 4-beat INCR burst to destination 3
        for (int i = 0; i < 4; i++) push_t(32'hA0 + 32'(i), (i == 3), 2'd3);
        push_b(1'b0, 2'b00);
        send_aw(1'b0, 13'h1800, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'hA0 + 32'(i), (i == 3));
        wait_drain();

        // Same burst with the sink stalling every other cycle
        toggle_en = 1'b1;
        for (int i = 0; i < 4; i++) push_t(32'hB0 + 32'(i), (i == 3), 2'd3);
        push_b(1'b1, 2'b00);
        send_aw(1'b1, 13'h1800, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'hB0 + 32'(i), (i == 3));
        wait_drain();
        toggle_en = 1'b0;

        // FIXED burst: both beats drained, SLVERR
        push_b(1'b0, 2'b10);
        send_aw(1'b0, 13'h0000, 8'd1, 3'd2, 2'b00);
        send_w(32'hE0, 1'b0);
        send_w(32'hE1, 1'b1);
        wait_drain();

        // Early wlast: awlen=3, wlast on beat 2
        push_t(32'hC0, 1'b0, 2'd1);
        push_t(32'hC1, 1'b1, 2'd1);
        push_b(1'b1, 2'b10);
        send_aw(1'b1, 13'h0800, 8'd3, 3'd2, 2'b01);
        send_w(32'hC0, 1'b0);
        send_w(32'hC1, 1'b1);
        wait_drain();

        // Late wlast: awlen=1, wlast on beat 4; beats 3-4 dropped
        push_t(32'hD0, 1'b0, 2'd2);
        push_t(32'hD1, 1'b1, 2'd2);
        push_b(1'b0, 2'b10);
        send_aw(1'b0, 13'h1000, 8'd1, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'hD0 + 32'(i), (i == 3));
        wait_drain();

        // Wrong awsize for a 32-bit bus
        push_b(1'b1, 2'b10);
        send_aw(1'b1, 13'h0000, 8'd0, 3'd3, 2'b01);
        send_w(32'hF0, 1'b1);
        wait_drain();

        // Reset after beat 2 of an 8-beat burst
        push_t(32'h90, 1'b0, 2'd0);
        push_t(32'h91, 1'b0, 2'd0);
        send_aw(1'b0, 13'h0000, 8'd7, 3'd2, 2'b01);
        send_w(32'h90, 1'b0);
        send_w(32'h91, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_awready", 64'(s_axi_awready), 64'd0);
        chk("midrst_wready", 64'(s_axi_wready), 64'd0);
        chk("midrst_t_pending", 64'(t_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_t(32'h55, 1'b1, 2'd0);
        push_b(1'b1, 2'b00);
        send_aw(1'b1, 13'h0000, 8'd0, 3'd2, 2'b01);
        send_w(32'h55, 1'b1);
        wait_drain();

        repeat (5) @(posedge clk);
        #1;
        chk("end_t_pending", 64'(t_q.size()), 64'd0);
        chk("end_b_pending", 64'(b_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
